// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: access size codes,
// controller state encoding and the default LED register address.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [31:0] LED_ADDR_DEFAULT = 32'h0000_2000;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } dmem_state_e;

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between a load/store unit (master) and the data
// memory controller (slave).
interface dmem_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store data replication and byte enables, plus load
// lane extraction with sign/zero extension.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wlanes,
   output logic [31:0] rdata
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rword >> {offset, 3'b000};
      be      = 4'b0000;
      wlanes  = wdata;
      rdata   = rword;
      case (size)
         SZ_BYTE: begin
            be     = 4'b0001 << offset;
            wlanes = {4{wdata[7:0]}};
            rdata  = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
         end
         SZ_HALF: begin
            be     = offset[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{wdata[15:0]}};
            rdata  = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
         end
         SZ_WORD: be = 4'b1111;
         default: ;
      endcase
   end

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-port data RAM controller with valid/ready request and response.
// Optional memory-mapped LED register enabled by DMEM_MMIO_LED_EN.
//
// state | meaning
// IDLE  | ready to accept a request
// RESP  | response presented, waiting for resp_ready
module data_memory_ctrl
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 2048,
   parameter int          LED_WIDTH   = 8,
   parameter logic [31:0] LED_ADDR    = LED_ADDR_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   dmem_if.slave                bus,
   output logic [LED_WIDTH-1:0] led
);

   localparam int AW = $clog2(DEPTH_WORDS);

`ifdef DMEM_MMIO_LED_EN
   localparam bit LED_EN = 1'b1;
`else
   localparam bit LED_EN = 1'b0;
`endif

   dmem_state_e state_q, state_d;
   logic [1:0]  size_q, size_d, off_q, off_d;
   logic        uns_q, uns_d, write_q, write_d, err_q, err_d, led_sel_q, led_sel_d;
   logic [31:0] ram_rd_q;
   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] led_word, rword, wlanes, al_rdata;
   logic [3:0]  be;
   logic [1:0]  al_size, al_off;
   logic        al_uns, acc, in_range, led_hit, misalign, req_err, ram_we, led_we;
   logic [AW-1:0] idx;

   assign idx      = bus.req_addr[AW+1:2];
   assign in_range = (bus.req_addr >> (AW + 2)) == 32'd0;
   assign led_hit  = LED_EN && (bus.req_addr == LED_ADDR);
   assign misalign = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                     ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
   assign req_err  = (bus.req_size == 2'b11) || misalign || !(in_range || led_hit);
   assign acc      = bus.req_valid && (state_q == IDLE);
   assign ram_we   = !reset && acc && bus.req_write && !req_err && !led_hit;
   assign led_we   = !reset && acc && bus.req_write && !req_err && led_hit;

   // In IDLE the aligner serves the store path from the live request; in RESP
   // it serves the load path from the fields captured at acceptance.
   assign al_size = (state_q == IDLE) ? bus.req_size        : size_q;
   assign al_off  = (state_q == IDLE) ? bus.req_addr[1:0]   : off_q;
   assign al_uns  = (state_q == IDLE) ? bus.req_unsigned    : uns_q;
   assign rword   = led_sel_q ? led_word : ram_rd_q;

   dmem_lane_align u_align (
      .size        (al_size),
      .offset      (al_off),
      .is_unsigned (al_uns),
      .wdata       (bus.req_wdata),
      .rword       (rword),
      .be          (be),
      .wlanes      (wlanes),
      .rdata       (al_rdata)
   );

   always_comb begin
      state_d   = state_q;
      size_d    = size_q;
      off_d     = off_q;
      uns_d     = uns_q;
      write_d   = write_q;
      err_d     = err_q;
      led_sel_d = led_sel_q;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            state_d   = RESP;
            size_d    = bus.req_size;
            off_d     = bus.req_addr[1:0];
            uns_d     = bus.req_unsigned;
            write_d   = bus.req_write;
            err_d     = req_err;
            led_sel_d = led_hit;
         end
         RESP: if (bus.resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         size_q    <= SZ_BYTE;
         off_q     <= 2'b00;
         uns_q     <= 1'b0;
         write_q   <= 1'b0;
         err_q     <= 1'b0;
         led_sel_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         size_q    <= size_d;
         off_q     <= off_d;
         uns_q     <= uns_d;
         write_q   <= write_d;
         err_q     <= err_d;
         led_sel_q <= led_sel_d;
      end
   end

   // RAM has no reset so it can map onto block memory.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
         end
      end
      if (acc) ram_rd_q <= mem[idx];
   end

`ifdef DMEM_MMIO_LED_EN
   logic [31:0] led_q, led_d;

   always_comb begin
      led_d = led_q;
      if (led_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) led_d[8*i +: 8] = wlanes[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) led_q <= '0;
      else       led_q <= led_d;
   end

   assign led_word = led_q;
   assign led      = led_q[LED_WIDTH-1:0];
`else
   assign led_word = 32'd0;
   assign led      = '0;
`endif

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_err   = (state_q == RESP) && err_q;
   assign bus.resp_rdata = ((state_q == RESP) && !err_q && !write_q) ? al_rdata : 32'd0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed self-checking bench for data_memory_ctrl; covers the LED register
// path when DMEM_MMIO_LED_EN is defined, otherwise checks LED_ADDR as RAM decode.
module tb_data_memory_ctrl;
   import dmem_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] led;
   int         n_chk = 0;
   int         n_fail = 0;

   dmem_if bus ();

   data_memory_ctrl #(.DEPTH_WORDS(2048), .LED_WIDTH(8), .LED_ADDR(32'h0000_2000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .led   (led)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
      end
   endtask

   // One full transaction; returns the response sampled in the RESP cycle.
   task automatic xact(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input bit uns,
                       output logic [31:0] rdata, output logic err);
      bit seen;
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_write    = wr;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.resp_ready   = 1'b1;
      seen  = 1'b0;
      rdata = 32'hxxxx_xxxx;
      err   = 1'bx;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         if (bus.resp_valid) begin
            seen  = 1'b1;
            rdata = bus.resp_rdata;
            err   = bus.resp_err;
            bus.req_valid = 1'b0;
         end
      end
      bus.req_valid = 1'b0;
      if (!seen) chk("resp_timeout", 32'd0, 32'd1);
   endtask

   logic [31:0] rd;
   logic        er;

   initial begin
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_addr     = 32'd0;
      bus.req_wdata    = 32'd0;
      bus.req_size     = SZ_WORD;
      bus.req_unsigned = 1'b0;
      bus.resp_ready   = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
      chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("rst_resp_err",   {31'd0, bus.resp_err},   32'd0);
      chk("rst_resp_rdata", bus.resp_rdata,          32'd0);
      chk("rst_led",        {24'd0, led},            32'd0);

      // byte store / signed load
      xact(1, 32'h4, 32'h1122_3344, SZ_WORD, 0, rd, er);
      chk("st_word_err", {31'd0, er}, 32'd0);
      xact(1, 32'h5, 32'h0000_00FF, SZ_BYTE, 0, rd, er);
      chk("st_byte_rdata", rd, 32'd0);
      chk("st_byte_err", {31'd0, er}, 32'd0);
      xact(0, 32'h5, 32'h0, SZ_BYTE, 0, rd, er);
      chk("ld_byte_s", rd, 32'hFFFF_FFFF);
      chk("ld_byte_s_err", {31'd0, er}, 32'd0);
      xact(0, 32'h5, 32'h0, SZ_BYTE, 1, rd, er);
      chk("ld_byte_u", rd, 32'h0000_00FF);
      xact(0, 32'h4, 32'h0, SZ_WORD, 1, rd, er);
      chk("ld_word_lanes", rd, 32'h1122_FF44);

      // word store / half and byte loads
      xact(1, 32'h100, 32'h8765_4321, SZ_WORD, 0, rd, er);
      xact(0, 32'h102, 32'h0, SZ_HALF, 1, rd, er);
      chk("ld_half_u_hi", rd, 32'h0000_8765);
      xact(0, 32'h102, 32'h0, SZ_HALF, 0, rd, er);
      chk("ld_half_s_hi", rd, 32'hFFFF_8765);
      xact(0, 32'h100, 32'h0, SZ_HALF, 0, rd, er);
      chk("ld_half_s_lo", rd, 32'h0000_4321);
      xact(0, 32'h103, 32'h0, SZ_BYTE, 0, rd, er);
      chk("ld_byte_s_3", rd, 32'hFFFF_FF87);
      xact(0, 32'h101, 32'h0, SZ_BYTE, 0, rd, er);
      chk("ld_byte_s_1", rd, 32'h0000_0043);
      xact(1, 32'h102, 32'h1234_BEEF, SZ_HALF, 0, rd, er);
      xact(0, 32'h100, 32'h0, SZ_WORD, 0, rd, er);
      chk("st_half_hi", rd, 32'hBEEF_4321);

      // error cases
      xact(1, 32'h101, 32'hDEAD_BEEF, SZ_WORD, 0, rd, er);
      chk("mis_word_err", {31'd0, er}, 32'd1);
      chk("mis_word_rdata", rd, 32'd0);
      xact(0, 32'h100, 32'h0, SZ_WORD, 0, rd, er);
      chk("mis_no_write", rd, 32'hBEEF_4321);
      xact(0, 32'h101, 32'h0, SZ_WORD, 0, rd, er);
      chk("mis_ld_rdata", rd, 32'd0);
      chk("mis_ld_err", {31'd0, er}, 32'd1);
      xact(0, 32'h103, 32'h0, SZ_HALF, 1, rd, er);
      chk("mis_half_err", {31'd0, er}, 32'd1);
      xact(1, 32'h100, 32'h0, 2'b11, 0, rd, er);
      chk("size11_err", {31'd0, er}, 32'd1);
      xact(0, 32'h100, 32'h0, SZ_WORD, 0, rd, er);
      chk("size11_no_write", rd, 32'hBEEF_4321);
      xact(0, 32'h2004, 32'h0, SZ_WORD, 0, rd, er);
      chk("oor_err", {31'd0, er}, 32'd1);
      xact(1, 32'h1FFC, 32'hCAFE_F00D, SZ_WORD, 0, rd, er);
      chk("last_st_err", {31'd0, er}, 32'd0);
      xact(0, 32'h1FFC, 32'h0, SZ_WORD, 0, rd, er);
      chk("last_ld", rd, 32'hCAFE_F00D);

      // backpressure with request fields churning
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 32'h100;
      bus.req_size  = SZ_WORD;
      bus.resp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
         chk("bp_rdata", bus.resp_rdata, 32'hBEEF_4321);
         chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
         bus.req_write    = 1'b1;
         bus.req_addr     = 32'h100 + 32'(i);
         bus.req_wdata    = 32'h0;
         bus.req_size     = 2'(i);
         bus.req_unsigned = i[0];
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      @(negedge clk);
      xact(0, 32'h100, 32'h0, SZ_WORD, 0, rd, er);
      chk("bp_no_write", rd, 32'hBEEF_4321);

`ifdef DMEM_MMIO_LED_EN
      xact(1, 32'h2000, 32'h0000_00A5, SZ_WORD, 0, rd, er);
      chk("led_st_err", {31'd0, er}, 32'd0);
      chk("led_val", {24'd0, led}, 32'h0000_00A5);
      xact(0, 32'h2000, 32'h0, SZ_WORD, 0, rd, er);
      chk("led_ld", rd, 32'h0000_00A5);
      xact(1, 32'h2001, 32'h0000_003C, SZ_BYTE, 0, rd, er);
      xact(0, 32'h2000, 32'h0, SZ_WORD, 0, rd, er);
      chk("led_byte_ld", rd, 32'h0000_3CA5);
      chk("led_byte_val", {24'd0, led}, 32'h0000_00A5);
`else
      xact(1, 32'h2000, 32'h0000_00A5, SZ_WORD, 0, rd, er);
      chk("noled_err", {31'd0, er}, 32'd1);
      chk("noled_led", {24'd0, led}, 32'd0);
`endif

      // reset while in RESP, with a store presented during reset
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_addr   = 32'h100;
      bus.req_size   = SZ_WORD;
      bus.resp_ready = 1'b0;
      @(negedge clk);
      chk("rr_in_resp", {31'd0, bus.resp_valid}, 32'd1);
      reset         = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h4;
      bus.req_wdata = 32'h0;
      @(negedge clk);
      chk("rr_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("rr_rdata", bus.resp_rdata, 32'd0);
      chk("rr_led", {24'd0, led}, 32'd0);
      @(negedge clk);
      reset          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      @(negedge clk);
      chk("rr_req_ready", {31'd0, bus.req_ready}, 32'd1);
      xact(0, 32'h4, 32'h0, SZ_WORD, 0, rd, er);
      chk("rr_no_write", rd, 32'h1122_FF44);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 2048: number of 32-bit RAM words, a power of two, at least 16.
REQ-002 Parameter LED_WIDTH, default 8: width of the LED output, 1..32.
REQ-003 Parameter LED_ADDR, default 32'h0000_2000: byte address of the memory-mapped LED register.
REQ-004 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port req_valid, input, 1: request present.
REQ-007 Port req_ready, output, 1: the controller can accept a request.
REQ-008 Port req_write, input, 1: 1 = store, 0 = load.
REQ-009 Port req_addr, input, 32: byte address.
REQ-010 Port req_wdata, input, 32: store data, right-aligned.
REQ-011 Port req_size, input, 2: access size; 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-012 Port req_unsigned, input, 1: on loads, 1 = zero-extend, 0 = sign-extend.
REQ-013 Port resp_valid, output, 1: response present.
REQ-014 Port resp_ready, input, 1: the consumer accepts the response.
REQ-015 Port resp_rdata, output, 32: load data, right-aligned and extended; 0 for stores and errors.
REQ-016 Port resp_err, output, 1: the request was misaligned, illegal or out of range.
REQ-017 Port led, output, LED_WIDTH: LED register bits [LED_WIDTH-1:0].

Function
REQ-018 The controller SHALL use two states, IDLE and RESP.
- req_ready = (state == IDLE).
- resp_valid = (state == RESP).
REQ-019 A request SHALL be accepted on a rising edge where req_valid && req_ready; the state then moves to RESP.
REQ-020 The state SHALL stay in RESP until a rising edge where resp_ready = 1, then move to IDLE.
- Maximum throughput: one request per 2 cycles.
- Response latency: 1 cycle after acceptance.
REQ-021 Word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2].
- The address is in range iff req_addr < 4*DEPTH_WORDS.
REQ-022 Error conditions SHALL be:
- size 11;
- half access with addr[0] = 1;
- word access with addr[1:0] != 0;
- an address that is neither in range nor equal to LED_ADDR (LED_ADDR only when enabled).
REQ-023 On error:
- No RAM or LED write SHALL occur.
- The response SHALL carry resp_err = 1 and resp_rdata = 0.
REQ-024 Stores SHALL write only the addressed byte lanes in the acceptance cycle.
- Byte: lane addr[1:0] = wdata[7:0].
- Half: lanes addr[1]*2 +{0,1} = wdata[15:0].
- Word: all four lanes.
REQ-025 Loads SHALL read the RAM synchronously at the acceptance edge.
- The selected lanes are shifted to bit 0 and extended per req_unsigned.
- Word loads ignore req_unsigned.
- The result SHALL be held stable throughout RESP.
REQ-026 Request fields SHALL be sampled only at acceptance; changes while in RESP SHALL have no effect.
REQ-027 RAM contents SHALL be undefined until first written; there is no initialisation file.

Reset
REQ-028 On reset the following SHALL be cleared:
- state to IDLE;
- resp_valid, resp_err and resp_rdata to 0;
- the LED register to 0.
REQ-029 Reset SHALL have priority over acceptance.
- A request presented in a reset cycle is not accepted and performs no write.
- A pending response is discarded.
REQ-030 RAM contents SHALL NOT be affected by reset.

Configuration
REQ-031 Macro DMEM_MMIO_LED_EN SHALL control the LED register.
REQ-032 When DMEM_MMIO_LED_EN is defined, accesses to LED_ADDR SHALL target a 32-bit LED register instead of RAM.
- Access rules are the same as RAM: byte-lane stores, extended loads, alignment checks.
- led = register[LED_WIDTH-1:0].
REQ-033 When DMEM_MMIO_LED_EN is not defined:
- No LED register SHALL exist.
- led SHALL be constant 0.
- LED_ADDR SHALL be decoded as an ordinary RAM address.

Structure
REQ-034 A shared package dmem_pkg SHALL hold:
- size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
- the state enum IDLE/RESP;
- the default LED_ADDR.
REQ-035 Lane steering and extension logic SHALL be a sub-module dmem_lane_align, shared by the load and store paths.

Verification
REQ-036 Byte store and signed load:
- Stimulus: store byte 0xFF at 0x5, then load byte signed at 0x5.
- Response: rdata 0xFFFF_FFFF, err 0, and bytes 0x4/0x6/0x7 unchanged.
REQ-037 Word store then unsigned half load:
- Stimulus: store word 0x8765_4321 at 0x100, then load half unsigned at 0x102.
- Response: rdata 0x0000_8765.
REQ-038 Misaligned word store:
- Stimulus: word store at 0x101.
- Response: err 1, rdata 0, and a later word load of 0x100 returns the old value.
REQ-039 Backpressure:
- Stimulus: load with resp_ready held 0 for 5 cycles while req fields change.
- Response: resp_valid stays high, rdata stays stable, req_ready stays 0.
REQ-040 LED register, macro defined:
- Stimulus: word store 0x0000_00A5 to 0x2000.
- Response: led = 0xA5 in the cycle after acceptance, and a load of 0x2000 returns 0xA5.
REQ-041 Reset in RESP:
- Stimulus: assert reset while in RESP.
- Response: resp_valid = 0 next cycle and req_ready = 1 after reset deasserts.
